// File: rtl/l2d_pkg.sv
// Shared widths, FSM encoding and request bundle for the L2 data-array access controller.
package l2d_pkg;

    localparam int SET_W  = 10;
    localparam int WAY_W  = 2;
    localparam int WEN_W  = 4;
    localparam int DATA_W = 156;

    // Two-state issue FSM: the array needs one dead cycle after every issue.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } l2d_state_e;

    // One requester's command fields, muxed as a unit after arbitration.
    typedef struct packed {
        logic              wr;
        logic [WAY_W-1:0]  way;
        logic [SET_W-1:0]  set;
        logic [WEN_W-1:0]  word_en;
        logic [DATA_W-1:0] wdata;
    } l2d_req_t;

endpackage

// File: rtl/l2d_arb.sv
// Fill-over-load fixed-priority arbiter with a starvation counter that lets
// a waiting load through after STARVE_MAX consecutive fill grants.
module l2d_arb
    import l2d_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic rclk,
    input  logic rst,
    input  logic idle,
    input  logic fill_vld,
    input  logic ld_vld,
    output logic fill_rdy,
    output logic ld_rdy
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             ld_pri_s;
    logic             fill_gnt_s;
    logic             ld_gnt_s;

    // Load wins when it has been starved long enough, or when fill is not asking.
    assign ld_pri_s   = (ld_vld && (starve_cnt_r == CNT_MAX)) || !fill_vld;
    assign fill_gnt_s = fill_vld & fill_rdy;
    assign ld_gnt_s   = ld_vld & ld_rdy;

    // Ready generation: at most one requester ready, none while busy or in reset.
    always_comb begin
        fill_rdy = 1'b0;
        ld_rdy   = 1'b0;
        if (rst || !idle) begin
            fill_rdy = 1'b0;
            ld_rdy   = 1'b0;
        end else if (ld_pri_s) begin
            ld_rdy = 1'b1;
        end else begin
            fill_rdy = 1'b1;
        end
    end

    // Count fill grants taken while a load waits; saturate, clear when load is served or absent.
    always_ff @(posedge rclk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (!ld_vld || ld_gnt_s) begin
            starve_cnt_r <= '0;
        end else if (fill_gnt_s && (starve_cnt_r != CNT_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2d_access_ctl.sv
// L2 data-array access controller: arbitrates fill and load requesters,
// drives the active-low array command and returns read data two cycles later.
module l2d_access_ctl
    import l2d_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              fill_vld,
    output logic              fill_rdy,
    input  logic              fill_wr,
    input  logic [WAY_W-1:0]  fill_way,
    input  logic [SET_W-1:0]  fill_set,
    input  logic [WEN_W-1:0]  fill_word_en,
    input  logic [DATA_W-1:0] fill_wdata,
    input  logic              ld_vld,
    output logic              ld_rdy,
    input  logic              ld_wr,
    input  logic [WAY_W-1:0]  ld_way,
    input  logic [SET_W-1:0]  ld_set,
    input  logic [WEN_W-1:0]  ld_word_en,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [SET_W-1:0]  set_l,
    output logic [WAY_W-1:0]  way_sel_l,
    output logic [WEN_W-1:0]  word_en_l,
    output logic              wr_en_l,
    output logic              col_offset_l,
    output logic [DATA_W-1:0] decc_in_l,
    input  logic [DATA_W-1:0] decc_out,
    output logic              rd_vld,
    output logic              rd_src,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic              wr_src
);

    l2d_state_e state_r;
    l2d_state_e state_nxt_s;
    logic       idle_s;
    logic       fill_gnt_s;
    logic       ld_gnt_s;
    logic       gnt_s;
    l2d_req_t   req_s;
    logic       rd_pend_r;
    logic       rd_pend_src_r;

    assign idle_s     = (state_r == IDLE);
    assign fill_gnt_s = fill_vld & fill_rdy;
    assign ld_gnt_s   = ld_vld & ld_rdy;
    assign gnt_s      = fill_gnt_s | ld_gnt_s;

    l2d_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .rclk     (rclk),
        .rst      (rst),
        .idle     (idle_s),
        .fill_vld (fill_vld),
        .ld_vld   (ld_vld),
        .fill_rdy (fill_rdy),
        .ld_rdy   (ld_rdy)
    );

    // Select the granted requester's fields (fill when nobody is granted; gated later).
    always_comb begin
        req_s = '{wr: fill_wr, way: fill_way, set: fill_set,
                  word_en: fill_word_en, wdata: fill_wdata};
        if (ld_gnt_s) begin
            req_s = '{wr: ld_wr, way: ld_way, set: ld_set,
                      word_en: ld_word_en, wdata: ld_wdata};
        end else begin
            req_s = '{wr: fill_wr, way: fill_way, set: fill_set,
                      word_en: fill_word_en, wdata: fill_wdata};
        end
    end

    // FSM next state: every grant is followed by exactly one blocked cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = gnt_s ? BUSY : IDLE;
            BUSY:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Array command: inverted granted fields in the grant cycle, all-ones otherwise.
    always_comb begin
        set_l        = '1;
        way_sel_l    = '1;
        word_en_l    = '1;
        wr_en_l      = 1'b1;
        col_offset_l = 1'b1;
        decc_in_l    = '1;
        if (gnt_s) begin
            set_l        = ~req_s.set;
            way_sel_l    = ~req_s.way;
            word_en_l    = ~req_s.word_en;
            wr_en_l      = ~req_s.wr;
            col_offset_l = 1'b0;
            decc_in_l    = ~req_s.wdata;
        end else begin
            set_l        = '1;
            way_sel_l    = '1;
            word_en_l    = '1;
            wr_en_l      = 1'b1;
            col_offset_l = 1'b1;
            decc_in_l    = '1;
        end
    end

    // Response pipeline: write ack one cycle after issue, read data captured the
    // cycle after issue and presented the cycle after that; rd_data holds until replaced.
    always_ff @(posedge rclk) begin
        if (rst) begin
            rd_pend_r     <= 1'b0;
            rd_pend_src_r <= 1'b0;
            rd_vld        <= 1'b0;
            rd_src        <= 1'b0;
            rd_data       <= '0;
            wr_done       <= 1'b0;
            wr_src        <= 1'b0;
        end else begin
            rd_pend_r     <= gnt_s & ~req_s.wr;
            rd_pend_src_r <= ld_gnt_s;
            wr_done       <= gnt_s & req_s.wr;
            if (gnt_s && req_s.wr) begin
                wr_src <= ld_gnt_s;
            end
            rd_vld <= rd_pend_r;
            if (rd_pend_r) begin
                rd_src  <= rd_pend_src_r;
                rd_data <= decc_out;
            end
        end
    end

endmodule

// File: tb/tb_l2d_access_ctl.sv
// Directed bench for l2d_access_ctl: reset, read/write paths, starvation
// ordering, back-to-back reads, way 00 and reset during a read.
module tb_l2d_access_ctl;

    logic         rclk;
    logic         rst;
    logic         fill_vld, fill_rdy, fill_wr;
    logic [1:0]   fill_way;
    logic [9:0]   fill_set;
    logic [3:0]   fill_word_en;
    logic [155:0] fill_wdata;
    logic         ld_vld, ld_rdy, ld_wr;
    logic [1:0]   ld_way;
    logic [9:0]   ld_set;
    logic [3:0]   ld_word_en;
    logic [155:0] ld_wdata;
    logic [9:0]   set_l;
    logic [1:0]   way_sel_l;
    logic [3:0]   word_en_l;
    logic         wr_en_l, col_offset_l;
    logic [155:0] decc_in_l, decc_out;
    logic         rd_vld, rd_src, wr_done, wr_src;
    logic [155:0] rd_data;

    int checks   = 0;
    int failures = 0;

    logic [155:0] ones, d1, d2, d3, d4, w1, w2;
    logic         exp_f, exp_l, exp_c;

    l2d_access_ctl #(.STARVE_MAX(4)) dut (
        .rclk(rclk), .rst(rst),
        .fill_vld(fill_vld), .fill_rdy(fill_rdy), .fill_wr(fill_wr),
        .fill_way(fill_way), .fill_set(fill_set), .fill_word_en(fill_word_en),
        .fill_wdata(fill_wdata),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_wr(ld_wr),
        .ld_way(ld_way), .ld_set(ld_set), .ld_word_en(ld_word_en),
        .ld_wdata(ld_wdata),
        .set_l(set_l), .way_sel_l(way_sel_l), .word_en_l(word_en_l),
        .wr_en_l(wr_en_l), .col_offset_l(col_offset_l), .decc_in_l(decc_in_l),
        .decc_out(decc_out),
        .rd_vld(rd_vld), .rd_src(rd_src), .rd_data(rd_data),
        .wr_done(wr_done), .wr_src(wr_src)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [155:0] obs, input logic [155:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic chk_array_idle(input string tag);
        chk({tag, ".set_l"},        156'(set_l),        156'(10'h3FF));
        chk({tag, ".way_sel_l"},    156'(way_sel_l),    156'(2'b11));
        chk({tag, ".word_en_l"},    156'(word_en_l),    156'(4'hF));
        chk({tag, ".wr_en_l"},      156'(wr_en_l),      156'(1'b1));
        chk({tag, ".col_offset_l"}, 156'(col_offset_l), 156'(1'b1));
        chk({tag, ".decc_in_l"},    decc_in_l,          ones);
    endtask

    initial begin
        ones = {156{1'b1}};
        d1   = {12{13'h1ABC}};
        d2   = {3{52'h1_2345_6789_ABCD}};
        d3   = {13{12'hC3A}};
        d4   = {39{4'h7}};
        w1   = {13{12'h5A1}};
        w2   = {39{4'h3}};

        rst = 1'b1;
        fill_vld = 1'b1; fill_wr = 1'b0; fill_way = 2'b00; fill_set = 10'h000;
        fill_word_en = 4'hF; fill_wdata = '0;
        ld_vld = 1'b1; ld_wr = 1'b0; ld_way = 2'b00; ld_set = 10'h000;
        ld_word_en = 4'hF; ld_wdata = '0;
        decc_out = '0;

        // Reset: requests present but nothing ready, array idle, outputs cleared.
        tick(); tick();
        chk("rst.fill_rdy", 156'(fill_rdy), 156'(1'b0));
        chk("rst.ld_rdy",   156'(ld_rdy),   156'(1'b0));
        chk_array_idle("rst");
        chk("rst.rd_vld",  156'(rd_vld),  156'(1'b0));
        chk("rst.wr_done", 156'(wr_done), 156'(1'b0));
        chk("rst.rd_src",  156'(rd_src),  156'(1'b0));
        chk("rst.wr_src",  156'(wr_src),  156'(1'b0));
        chk("rst.rd_data", rd_data, 156'(0));
        rst = 1'b0; fill_vld = 1'b0; ld_vld = 1'b0;
        tick();

        // Single ld read, way 01, set 0x155.
        ld_vld = 1'b1; ld_wr = 1'b0; ld_way = 2'b01; ld_set = 10'h155; ld_word_en = 4'hF;
        #1;
        chk("rd1.ld_rdy",       156'(ld_rdy),       156'(1'b1));
        chk("rd1.fill_rdy",     156'(fill_rdy),     156'(1'b0));
        chk("rd1.set_l",        156'(set_l),        156'(10'h2AA));
        chk("rd1.way_sel_l",    156'(way_sel_l),    156'(2'b10));
        chk("rd1.col_offset_l", 156'(col_offset_l), 156'(1'b0));
        chk("rd1.wr_en_l",      156'(wr_en_l),      156'(1'b1));
        tick();
        ld_vld = 1'b0; decc_out = d1;
        #1;
        chk("rd1.busy_ld_rdy", 156'(ld_rdy), 156'(1'b0));
        chk_array_idle("rd1.busy");
        chk("rd1.t1_rd_vld", 156'(rd_vld), 156'(1'b0));
        tick();
        decc_out = '0;
        #1;
        chk("rd1.rd_vld",  156'(rd_vld), 156'(1'b1));
        chk("rd1.rd_src",  156'(rd_src), 156'(1'b1));
        chk("rd1.rd_data", rd_data, d1);
        tick();
        chk("rd1.pulse_rd_vld", 156'(rd_vld), 156'(1'b0));
        chk("rd1.hold_rd_data", rd_data, d1);

        // Fill write, word_en 0101.
        fill_vld = 1'b1; fill_wr = 1'b1; fill_way = 2'b10; fill_set = 10'h0F0;
        fill_word_en = 4'b0101; fill_wdata = w1;
        #1;
        chk("wr1.fill_rdy",  156'(fill_rdy),  156'(1'b1));
        chk("wr1.word_en_l", 156'(word_en_l), 156'(4'b1010));
        chk("wr1.wr_en_l",   156'(wr_en_l),   156'(1'b0));
        chk("wr1.set_l",     156'(set_l),     156'(10'h30F));
        chk("wr1.way_sel_l", 156'(way_sel_l), 156'(2'b01));
        chk("wr1.decc_in_l", decc_in_l, ~w1);
        tick();
        ld_vld = 1'b1;
        #1;
        chk("wr1.wr_done",  156'(wr_done),  156'(1'b1));
        chk("wr1.wr_src",   156'(wr_src),   156'(1'b0));
        chk("wr1.ld_rdy",   156'(ld_rdy),   156'(1'b0));
        chk("wr1.fill_rdy_busy", 156'(fill_rdy), 156'(1'b0));
        fill_vld = 1'b0; ld_vld = 1'b0; fill_wr = 1'b0;
        tick();
        chk("wr1.no_rd_vld",    156'(rd_vld),  156'(1'b0));
        chk("wr1.pulse_wr_done", 156'(wr_done), 156'(1'b0));

        // Ld write, source must report 1.
        ld_vld = 1'b1; ld_wr = 1'b1; ld_word_en = 4'b0011; ld_wdata = w2;
        #1;
        chk("wr2.ld_rdy",    156'(ld_rdy),    156'(1'b1));
        chk("wr2.word_en_l", 156'(word_en_l), 156'(4'b1100));
        chk("wr2.decc_in_l", decc_in_l, ~w2);
        tick();
        ld_vld = 1'b0; ld_wr = 1'b0;
        #1;
        chk("wr2.wr_done", 156'(wr_done), 156'(1'b1));
        chk("wr2.wr_src",  156'(wr_src),  156'(1'b1));
        tick();
        chk("wr2.no_rd_vld", 156'(rd_vld), 156'(1'b0));

        // Starvation: both held high -> fill x4, ld, fill; issues every other cycle.
        fill_vld = 1'b1; ld_vld = 1'b1; fill_wr = 1'b0; ld_wr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            exp_l = (i == 8);
            exp_f = ((i % 2) == 0) && (i != 8);
            exp_c = ((i % 2) == 0) ? 1'b0 : 1'b1;
            #1;
            chk($sformatf("stv%0d.fill_rdy", i), 156'(fill_rdy), 156'(exp_f));
            chk($sformatf("stv%0d.ld_rdy", i),   156'(ld_rdy),   156'(exp_l));
            chk($sformatf("stv%0d.col_off", i),  156'(col_offset_l), 156'(exp_c));
            tick();
        end
        fill_vld = 1'b0; ld_vld = 1'b0;
        tick(); tick(); tick();

        // Back-to-back reads at T and T+2.
        ld_vld = 1'b1; ld_way = 2'b11; ld_set = 10'h001;
        #1;
        chk("b2b.ld_rdy", 156'(ld_rdy), 156'(1'b1));
        tick();
        ld_vld = 1'b0; decc_out = d2;
        tick();
        decc_out = '0;
        fill_vld = 1'b1; fill_wr = 1'b0; fill_way = 2'b01; fill_set = 10'h002;
        #1;
        chk("b2b.fill_rdy_t2", 156'(fill_rdy), 156'(1'b1));
        chk("b2b.rd_vld0",  156'(rd_vld), 156'(1'b1));
        chk("b2b.rd_src0",  156'(rd_src), 156'(1'b1));
        chk("b2b.rd_data0", rd_data, d2);
        tick();
        fill_vld = 1'b0; decc_out = d3;
        #1;
        chk("b2b.gap_rd_vld", 156'(rd_vld), 156'(1'b0));
        tick();
        decc_out = '0;
        #1;
        chk("b2b.rd_vld1",  156'(rd_vld), 156'(1'b1));
        chk("b2b.rd_src1",  156'(rd_src), 156'(1'b0));
        chk("b2b.rd_data1", rd_data, d3);
        tick();

        // Way 00 read passes through unchanged and returns the array's zero.
        ld_vld = 1'b1; ld_way = 2'b00; ld_set = 10'h3FF;
        #1;
        chk("w00.way_sel_l", 156'(way_sel_l), 156'(2'b11));
        chk("w00.set_l",     156'(set_l),     156'(10'h000));
        tick();
        ld_vld = 1'b0; decc_out = '0;
        tick();
        chk("w00.rd_vld",  156'(rd_vld), 156'(1'b1));
        chk("w00.rd_src",  156'(rd_src), 156'(1'b1));
        chk("w00.rd_data", rd_data, 156'(0));
        tick();

        // Reset during a read in flight drops the response.
        fill_vld = 1'b1; fill_way = 2'b01; fill_set = 10'h123;
        #1;
        chk("mrst.fill_rdy", 156'(fill_rdy), 156'(1'b1));
        tick();
        fill_vld = 1'b0; rst = 1'b1; decc_out = d4; ld_vld = 1'b1;
        #1;
        chk("mrst.ld_rdy_in_rst", 156'(ld_rdy), 156'(1'b0));
        chk_array_idle("mrst.t1");
        tick();
        rst = 1'b0; ld_vld = 1'b0; decc_out = '0;
        #1;
        chk("mrst.rd_vld",  156'(rd_vld), 156'(1'b0));
        chk("mrst.rd_data", rd_data, 156'(0));
        chk_array_idle("mrst.t2");
        tick();
        chk("mrst.rd_vld_after", 156'(rd_vld), 156'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
